sit_iter_core: RTL

- Iterative, clocked successor to the combinational SiT cipher path.
- Expands the key once and caches the round keys, then runs one SiT round per cycle for both encrypt and decrypt.
- Uses valid/ready handshakes on the data path.
- Generalised in block width and round count, with a per-block mode select; sits between the host data interface and the crypto result buffer.

---
 rtl/sit_iter_core.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sit_iter_core.sv
// Iterative SiT cipher core: cached key expansion, then one round per cycle for encrypt/decrypt.
// Latency: key expansion NUM_ROUNDS cycles; a block accepted on edge T is presented on edge T+NUM_ROUNDS.
// Backpressure: out_data holds until out_ready; in_ready is low outside READY. Optional CBC chaining: SIT_CBC_EN.
module sit_iter_core #(
   parameter int BLK_W      = 64,
   parameter int KEY_W      = BLK_W,
   parameter int NUM_ROUNDS = 5,
   parameter int RK_W       = BLK_W / 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_load,
   input  logic [KEY_W-1:0] key_in,
   output logic             key_ready,
`ifdef SIT_CBC_EN
   input  logic             iv_load,
   input  logic [BLK_W-1:0] iv_in,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_mode,
   input  logic [BLK_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             busy
);

   // Counter is at least 2 bits so the low bits can select one of the four key segments.
   localparam int CW = (NUM_ROUNDS > 4) ? $clog2(NUM_ROUNDS) : 2;
   localparam logic [CW-1:0] LAST = CW'(NUM_ROUNDS - 1);

   typedef enum logic [2:0] {IDLE, KEXP, READY, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     kidx, rnd;
   logic [KEY_W-1:0]  key_reg;
   logic [RK_W-1:0]   rk_mem [NUM_ROUNDS];
   logic [RK_W-1:0]   seg [4];
   logic [RK_W-1:0]   kexp_val, rk_cur;
   logic [BLK_W-1:0]  data_reg, round_out;
   logic              mode_reg;
   logic              accept;
`ifdef SIT_CBC_EN
   logic [BLK_W-1:0]  chain, chain_pend;
`endif

   // 4-bit substitution box shared by key expansion and the round function.
   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: sbox = 4'h3;  4'h1: sbox = 4'hF;  4'h2: sbox = 4'hE;  4'h3: sbox = 4'h0;
         4'h4: sbox = 4'h5;  4'h5: sbox = 4'h4;  4'h6: sbox = 4'hB;  4'h7: sbox = 4'hC;
         4'h8: sbox = 4'hD;  4'h9: sbox = 4'hA;  4'hA: sbox = 4'h9;  4'hB: sbox = 4'h6;
         4'hC: sbox = 4'h7;  4'hD: sbox = 4'h8;  4'hE: sbox = 4'h2;  default: sbox = 4'h1;
      endcase
   endfunction

   // F: nibble-wise S-box, then rotate left by one bit.
   function automatic logic [RK_W-1:0] f_fn(input logic [RK_W-1:0] x);
      logic [RK_W-1:0] s, r;
      s = x;
      r = '0;
      for (int i = 0; i + 4 <= RK_W; i += 4) s[i +: 4] = sbox(x[i +: 4]);
      for (int j = 0; j < RK_W; j++) r[(j + 1) % RK_W] = s[j];
      return r;
   endfunction

   // Round: XNOR outer words with the key, F feeds the inner words, words are reordered.
   function automatic logic [BLK_W-1:0] enc_round(input logic [BLK_W-1:0] d, input logic [RK_W-1:0] k);
      logic [RK_W-1:0] a, dd, x, y;
      a  = ~(d[BLK_W-1 -: RK_W] ^ k);
      dd = ~(d[RK_W-1:0] ^ k);
      x  = f_fn(a) ^ d[2*RK_W-1 -: RK_W];
      y  = f_fn(dd) ^ d[3*RK_W-1 -: RK_W];
      return {x, dd, a, y};
   endfunction

   function automatic logic [BLK_W-1:0] dec_round(input logic [BLK_W-1:0] d, input logic [RK_W-1:0] k);
      logic [RK_W-1:0] x, dd, a, y;
      x  = d[BLK_W-1 -: RK_W];
      dd = d[3*RK_W-1 -: RK_W];
      a  = d[2*RK_W-1 -: RK_W];
      y  = d[RK_W-1:0];
      return {~(a ^ k), y ^ f_fn(dd), x ^ f_fn(a), ~(dd ^ k)};
   endfunction

`ifdef SIT_CBC_EN
   assign accept = (state == READY) && in_valid && !key_load && !iv_load;
`else
   assign accept = (state == READY) && in_valid && !key_load;
`endif
   assign in_ready = (state == READY);
   assign busy     = (state == KEXP) || (state == RUN) || (state == DONE);

   // Key segments (most significant first) and the round key produced this KEXP cycle.
   always_comb begin
      for (int s = 0; s < 4; s++) seg[s] = key_reg[KEY_W-1-s*RK_W -: RK_W];
      kexp_val = '0;
      if (int'(kidx) < 4) kexp_val = f_fn(seg[kidx[1:0]]);
      else kexp_val = rk_mem[kidx - CW'(1)] ^ rk_mem[kidx - CW'(2)] ^
                      rk_mem[kidx - CW'(3)] ^ rk_mem[kidx - CW'(4)];
   end

   // One round of the current block; decrypt walks the key cache backwards.
   always_comb begin
      rk_cur    = rk_mem[mode_reg ? (LAST - rnd) : rnd];
      round_out = mode_reg ? dec_round(data_reg, rk_cur) : enc_round(data_reg, rk_cur);
   end

   // Next-state logic; key_load outranks a same-cycle block in READY and is ignored while a block is in flight.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (key_load) state_nxt = KEXP;
         KEXP:    if (!key_load && kidx == LAST) state_nxt = READY;
         READY:   if (key_load) state_nxt = KEXP;
                  else if (accept) state_nxt = RUN;
         RUN:     if (rnd == LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = READY;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Key cache, round counter, block datapath and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kidx      <= '0;
         rnd       <= '0;
         key_reg   <= '0;
         key_ready <= 1'b0;
         data_reg  <= '0;
         mode_reg  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         for (int i = 0; i < NUM_ROUNDS; i++) rk_mem[i] <= '0;
`ifdef SIT_CBC_EN
         chain      <= '0;
         chain_pend <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (key_load) begin
               key_reg <= key_in;
               kidx    <= '0;
            end
            KEXP: if (key_load) begin
               key_reg <= key_in;
               kidx    <= '0;
            end else begin
               rk_mem[kidx] <= kexp_val;
               if (kidx == LAST) key_ready <= 1'b1;
               else              kidx <= kidx + CW'(1);
            end
            READY: if (key_load) begin
               key_reg   <= key_in;
               kidx      <= '0;
               key_ready <= 1'b0;
`ifdef SIT_CBC_EN
            end else if (iv_load) begin
               chain <= iv_in;
`endif
            end else if (accept) begin
               mode_reg <= in_mode;
               rnd      <= '0;
`ifdef SIT_CBC_EN
               data_reg   <= in_mode ? in_data : (in_data ^ chain);
               chain_pend <= in_data;
`else
               data_reg <= in_data;
`endif
            end
            RUN: begin
               data_reg <= round_out;
               if (rnd == LAST) begin
                  out_valid <= 1'b1;
`ifdef SIT_CBC_EN
                  out_data <= mode_reg ? (round_out ^ chain) : round_out;
                  chain    <= mode_reg ? chain_pend : round_out;
`else
                  out_data <= round_out;
`endif
               end else begin
                  rnd <= rnd + CW'(1);
               end
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
